// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter and command sequencer for a shared bank of JK flip-flops.
// Each accepted command drives J/K for one cycle, waits a settle window, then checks Q.
module jk_bank_arbiter #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_mask,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_mask,
  output logic             req1_ready,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             done_id
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
  typedef enum logic [1:0] {OP_INC, OP_SET, OP_RESET, OP_TOGGLE} op_t;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t           state, state_next;
  logic             last_grant;
  logic [CW-1:0]    cnt;
  op_t              op_q, sel_op;
  logic [WIDTH-1:0] mask_q, sel_mask;
  logic [WIDTH-1:0] expected_q, expected_next;
  logic             id_q;
  logic             grant0, grant1, accept, settle_last;
  logic             carry;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      // On a tie the requester that was not granted last wins.
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign accept     = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign sel_op     = grant1 ? op_t'(req1_op) : op_t'(req0_op);
  assign sel_mask   = grant1 ? req1_mask : req0_mask;
  assign busy       = (state != IDLE);
  assign settle_last = (state == SETTLE) && (cnt == CW'(SETTLE_CYCLES - 1));

  always_comb begin
    expected_next = q;
    case (sel_op)
      OP_SET:    expected_next = q | sel_mask;
      OP_RESET:  expected_next = q & ~sel_mask;
      OP_TOGGLE: expected_next = q ^ sel_mask;
      OP_INC:    expected_next = q + WIDTH'(1);
      default:   expected_next = q;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = SETTLE;
      SETTLE:  if (settle_last) state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    j     = '0;
    k     = '0;
    carry = 1'b1;
    if (state == DRIVE && !rst) begin
      case (op_q)
        OP_SET:    j = mask_q;
        OP_RESET:  k = mask_q;
        OP_TOGGLE: begin
          j = mask_q;
          k = mask_q;
        end
        OP_INC: begin
          // Ripple increment: bit i toggles when all lower live Q bits are one.
          for (int i = 0; i < WIDTH; i++) begin
            j[i]  = carry;
            k[i]  = carry;
            carry = carry & q[i];
          end
        end
        default: begin
          j = '0;
          k = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      done_id    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) last_grant <= grant1;
      cnt  <= (state == SETTLE) ? cnt + CW'(1) : '0;
      done <= settle_last;
      err  <= settle_last && (q != expected_q);
      if (settle_last) done_id <= id_q;
    end
  end

  // NOTE: command payload registers carry no reset; they are only read after an accept loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= sel_op;
      mask_q     <= sel_mask;
      id_q       <= grant1;
      expected_q <= expected_next;
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboard bench for jk_bank_arbiter: instance a uses a 1-cycle settle, instance b a 3-cycle settle.
module tb_jk_bank_arbiter;

  localparam logic [1:0] OP_INC = 2'b00, OP_SET = 2'b01, OP_RST = 2'b10, OP_TOG = 2'b11;

  typedef struct {
    int         inst;
    logic       id;
    logic       err;
    logic [3:0] qv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v   [2][2];
  logic [1:0] op  [2][2];
  logic [3:0] mk  [2][2];
  logic       rdy [2][2];
  logic [3:0] bq [2], bj [2], bk [2], lv [2];
  logic       ld [2], ign [2];
  logic       bsy [2], dn [2], er [2], did [2];

  exp_t sb [$];
  int   acc [$];
  int   last_acc [2] = '{-100, -100};
  int   n_checks = 0;
  int   n_fail = 0;

  jk_bank_arbiter #(.WIDTH(4), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0_valid(v[0][0]), .req0_op(op[0][0]), .req0_mask(mk[0][0]), .req0_ready(rdy[0][0]),
    .req1_valid(v[0][1]), .req1_op(op[0][1]), .req1_mask(mk[0][1]), .req1_ready(rdy[0][1]),
    .j(bj[0]), .k(bk[0]), .q(bq[0]),
    .busy(bsy[0]), .done(dn[0]), .err(er[0]), .done_id(did[0])
  );

  jk_bank_arbiter #(.WIDTH(4), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0_valid(v[1][0]), .req0_op(op[1][0]), .req0_mask(mk[1][0]), .req0_ready(rdy[1][0]),
    .req1_valid(v[1][1]), .req1_op(op[1][1]), .req1_mask(mk[1][1]), .req1_ready(rdy[1][1]),
    .j(bj[1]), .k(bk[1]), .q(bq[1]),
    .busy(bsy[1]), .done(dn[1]), .err(er[1]), .done_id(did[1])
  );

  // JK bank models: Qn = J & ~Q | ~K & Q, with preload and a stuck mode.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ld[i]) bq[i] <= lv[i];
      else if (!ign[i]) bq[i] <= (bj[i] & ~bq[i]) | (~bk[i] & bq[i]);
    end
  end

  function automatic int lat(input int inst);
    return (inst == 0) ? 3 : 5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: records accepts, pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (rst) begin
      acc.delete();
      last_acc[0] = -100;
      last_acc[1] = -100;
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 2; r++) begin
          if (v[i][r] && rdy[i][r]) begin
            acc.push_back(cyc);
            check("accept_spacing_ok", 32'(cyc - last_acc[i] >= lat(i) + 1), 1);
            last_acc[i] = cyc;
          end
        end
        if (dn[i]) begin
          if (sb.size() == 0 || acc.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            int   a;
            e = sb.pop_front();
            a = acc.pop_front();
            check("done_inst", i, e.inst);
            check("done_id", {31'b0, did[i]}, {31'b0, e.id});
            check("err", {31'b0, er[i]}, {31'b0, e.err});
            check("bank_q", {28'b0, bq[i]}, {28'b0, e.qv});
            check("latency", cyc - a, lat(i));
          end
        end
      end
    end
  end

  task automatic expect_done(input int inst, input logic id, input logic e, input logic [3:0] qv);
    exp_t x;
    x.inst = inst; x.id = id; x.err = e; x.qv = qv;
    sb.push_back(x);
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the accept (the DRIVE cycle).
  task automatic send(input int inst, input int id, input logic [1:0] o, input logic [3:0] m);
    int n = 0;
    v[inst][id]  = 1'b1;
    op[inst][id] = o;
    mk[inst][id] = m;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[inst][id] && n < 64);
    check("ready_seen", {31'b0, rdy[inst][id]}, 1);
    @(posedge clk);
    #1;
    v[inst][id] = 1'b0;
  endtask

  task automatic load(input int inst, input logic [3:0] val);
    ld[inst] = 1'b1;
    lv[inst] = val;
    @(posedge clk);
    #1;
    ld[inst] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ign[i] = 1'b0;
      ld[i]  = 1'b0;
      lv[i]  = 4'b0;
      for (int r = 0; r < 2; r++) begin
        v[i][r]  = 1'b0;
        op[i][r] = OP_INC;
        mk[i][r] = 4'b0;
      end
    end
    // Reset with a valid held: no ready, outputs at reset values, command dropped.
    v[0][0] = 1'b1; op[0][0] = OP_SET; mk[0][0] = 4'b0101;
    ld[0] = 1'b1; ld[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ld[0] = 1'b0; ld[1] = 1'b0;
    check("rst_ready0", {31'b0, rdy[0][0]}, 0);
    check("rst_ready1", {31'b0, rdy[0][1]}, 0);
    check("rst_busy", {31'b0, bsy[0]}, 0);
    check("rst_done", {31'b0, dn[0]}, 0);
    check("rst_err", {31'b0, er[0]}, 0);
    check("rst_done_id", {31'b0, did[0]}, 0);
    check("rst_j", {28'b0, bj[0]}, 0);
    check("rst_k", {28'b0, bk[0]}, 0);
    check("rst_busy_b", {31'b0, bsy[1]}, 0);
    v[0][0] = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // SET 0101 on q=0000.
    expect_done(0, 1'b0, 1'b0, 4'b0101);
    send(0, 0, OP_SET, 4'b0101);
    check("set_drive_j", {28'b0, bj[0]}, 32'b0101);
    check("set_drive_k", {28'b0, bk[0]}, 32'b0000);
    check("set_busy", {31'b0, bsy[0]}, 1);
    wait_idle();

    // Fresh reset so the first tie goes to req0; both toggle continuously.
    rst = 1'b1;
    load(0, 4'b0000);
    rst = 1'b0;
    expect_done(0, 1'b0, 1'b0, 4'b0011);
    expect_done(0, 1'b1, 1'b0, 4'b0101);
    expect_done(0, 1'b0, 1'b0, 4'b0110);
    expect_done(0, 1'b1, 1'b0, 4'b0000);
    fork
      begin
        send(0, 0, OP_TOG, 4'b0011);
        send(0, 0, OP_TOG, 4'b0011);
      end
      begin
        send(0, 1, OP_TOG, 4'b0110);
        send(0, 1, OP_TOG, 4'b0110);
      end
    join
    wait_idle();

    // INC on all-ones wraps to zero.
    load(0, 4'b1111);
    expect_done(0, 1'b1, 1'b0, 4'b0000);
    send(0, 1, OP_INC, 4'b0000);
    check("inc_drive_j", {28'b0, bj[0]}, 32'b1111);
    check("inc_drive_k", {28'b0, bk[0]}, 32'b1111);
    wait_idle();

    // Stuck bank: SET 1000 does not land, expect err.
    load(0, 4'b0000);
    ign[0] = 1'b1;
    expect_done(0, 1'b0, 1'b1, 4'b0000);
    send(0, 0, OP_SET, 4'b1000);
    check("stuck_drive_j", {28'b0, bj[0]}, 32'b1000);
    wait_idle();
    ign[0] = 1'b0;

    // Reset during SETTLE aborts the command with no done pulse.
    load(0, 4'b0000);
    send(0, 1, OP_SET, 4'b0001);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'b0, bsy[0]}, 0);
    check("abort_j", {28'b0, bj[0]}, 0);
    check("abort_k", {28'b0, bk[0]}, 0);
    check("abort_done", {31'b0, dn[0]}, 0);
    repeat (3) @(posedge clk);
    #1;
    expect_done(0, 1'b0, 1'b0, 4'b0000);
    send(0, 0, OP_RST, 4'b0001);
    wait_idle();

    // Three-cycle settle: RESET 0011 on 1111.
    load(1, 4'b1111);
    expect_done(1, 1'b0, 1'b0, 4'b1100);
    send(1, 0, OP_RST, 4'b0011);
    check("s3_drive_k", {28'b0, bk[1]}, 32'b0011);
    wait_idle();

    repeat (4) @(posedge clk);
    check("acc_leftover", acc.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
